// File: rtl/pipelined_addsub_unit.sv
// Pipelined WIDTH-bit adder/subtractor driven by synchronised push-buttons.
// The carry chain is cut into STAGES registered SEG-bit segments; accumulate mode reuses Sum as X.
module pipelined_addsub_unit #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LoadA,
  input  logic             LoadB,
  input  logic             Run,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] A_q,
  output logic [WIDTH-1:0] B_q,
  output logic [WIDTH-1:0] Sum,
  output logic             Co,
  output logic             Ovf,
  output logic             Busy,
  output logic             Done
);

  localparam int SEG = WIDTH / STAGES;

  generate
    if (WIDTH % STAGES != 0) begin : g_bad_params
      $error("pipelined_addsub_unit: WIDTH must be a multiple of STAGES");
    end
  endgenerate

  typedef enum logic {IDLE, BUSY} state_t;

  logic [2:0] btn;
  logic [2:0] sync1_reg;
  logic [2:0] sync2_reg;
  logic [2:0] prev_reg;
  logic [2:0] arm_reg;
  logic [2:0] press;
  logic       load_a_pulse;
  logic       load_b_pulse;
  logic       run_pulse;

  state_t state_reg;
  state_t state_next;
  logic   launch;

  logic [WIDTH-1:0] px_reg [STAGES];
  logic [WIDTH-1:0] py_reg [STAGES];
  logic [WIDTH-1:0] ps_reg [STAGES];
  logic [STAGES-1:0] pc_reg;
  logic [STAGES-1:0] pv_reg;

  logic [WIDTH-1:0] stage_sum [STAGES];
  logic             seg_co    [STAGES];

  assign btn = {Run, LoadB, LoadA};

  // arm_reg keeps edge detection quiet until the chain holds real button samples,
  // so a button held through reset release never produces a pulse.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync1_reg <= '1;
      sync2_reg <= '1;
      prev_reg  <= '1;
      arm_reg   <= '0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      arm_reg   <= {arm_reg[1:0], 1'b1};
    end
  end

  assign press        = {3{arm_reg[2]}} & prev_reg & ~sync2_reg;
  assign load_a_pulse = press[0];
  assign load_b_pulse = press[1];
  assign run_pulse    = press[2];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      A_q <= '0;
      B_q <= '0;
    end else begin
      if (load_a_pulse) A_q <= SW;
      if (load_b_pulse) B_q <= SW;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    launch     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (run_pulse) begin
          state_next = BUSY;
          launch     = 1'b1;
        end
      end
      BUSY: begin
        if (pv_reg[STAGES-1]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign Busy = (state_reg == BUSY);

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [SEG:0]     seg_add;
      logic [WIDTH-1:0] merged;

      assign seg_add = {1'b0, px_reg[gi][gi*SEG +: SEG]}
                     + {1'b0, py_reg[gi][gi*SEG +: SEG]}
                     + {{SEG{1'b0}}, pc_reg[gi]};

      always_comb begin
        merged = ps_reg[gi];
        merged[gi*SEG +: SEG] = seg_add[SEG-1:0];
      end

      assign stage_sum[gi] = merged;
      assign seg_co[gi]    = seg_add[SEG];
    end
  endgenerate

  // Bank 0 is loaded at launch; bank k holds the inputs of segment k.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int k = 0; k < STAGES; k++) begin
        px_reg[k] <= '0;
        py_reg[k] <= '0;
        ps_reg[k] <= '0;
      end
      pc_reg <= '0;
      pv_reg <= '0;
      Sum    <= '0;
      Co     <= 1'b0;
      Ovf    <= 1'b0;
      Done   <= 1'b0;
    end else begin
      pv_reg[0] <= launch;
      if (launch) begin
        px_reg[0] <= Mode[1] ? Sum : A_q;
        py_reg[0] <= Mode[0] ? ~B_q : B_q;
        pc_reg[0] <= Mode[0];
        ps_reg[0] <= '0;
      end
      for (int k = 1; k < STAGES; k++) begin
        pv_reg[k] <= pv_reg[k-1];
        if (pv_reg[k-1]) begin
          px_reg[k] <= px_reg[k-1];
          py_reg[k] <= py_reg[k-1];
          ps_reg[k] <= stage_sum[k-1];
          pc_reg[k] <= seg_co[k-1];
        end
      end
      Done <= pv_reg[STAGES-1];
      if (pv_reg[STAGES-1]) begin
        Sum <= stage_sum[STAGES-1];
        Co  <= seg_co[STAGES-1];
        Ovf <= (px_reg[STAGES-1][WIDTH-1] == py_reg[STAGES-1][WIDTH-1]) &&
               (stage_sum[STAGES-1][WIDTH-1] != px_reg[STAGES-1][WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_pipelined_addsub_unit.sv
// Bench for pipelined_addsub_unit: a 16/4 and a 32/8 instance share buttons and mode,
// a scoreboard per instance is fed at each Run and drained on Done.
module tb_pipelined_addsub_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        la = 1'b1, lb = 1'b1, run = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic [15:0] sw16 = '0;
  logic [31:0] sw32 = '0;

  logic [15:0] a16, b16, sum16;
  logic        co16, ovf16, busy16, done16;
  logic [31:0] a32, b32, sum32;
  logic        co32, ovf32, busy32, done32;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    longint sum;
    bit     co;
    bit     ovf;
    int     cyc;
  } exp_t;

  exp_t q16[$];
  exp_t q32[$];
  exp_t e16, e32;

  longint ma16 = 0, mb16 = 0, ms16 = 0;
  longint ma32 = 0, mb32 = 0, ms32 = 0;

  pipelined_addsub_unit #(.WIDTH(16), .STAGES(4)) dut16 (
    .Clk(clk), .Reset(reset_n), .LoadA(la), .LoadB(lb), .Run(run), .Mode(mode), .SW(sw16),
    .A_q(a16), .B_q(b16), .Sum(sum16), .Co(co16), .Ovf(ovf16), .Busy(busy16), .Done(done16)
  );

  pipelined_addsub_unit #(.WIDTH(32), .STAGES(8)) dut32 (
    .Clk(clk), .Reset(reset_n), .LoadA(la), .LoadB(lb), .Run(run), .Mode(mode), .SW(sw32),
    .A_q(a32), .B_q(b32), .Sum(sum32), .Co(co32), .Ovf(ovf32), .Busy(busy32), .Done(done32)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Plain-arithmetic reference: unsigned result/carry and signed overflow from integer ranges.
  function automatic void ref_op(input int w, input logic [1:0] m, input longint a, input longint b,
                                 input longint s, output longint r, output bit co, output bit ovf);
    longint modv, half, x, sx, sb, t;
    modv = longint'(1) << w;
    half = modv / 2;
    x  = m[1] ? s : a;
    sx = (x >= half) ? x - modv : x;
    sb = (b >= half) ? b - modv : b;
    if (!m[0]) begin
      t  = x + b;
      co = (t >= modv);
      r  = t % modv;
      t  = sx + sb;
    end else begin
      co = (x >= b);
      r  = (x - b + modv) % modv;
      t  = sx - sb;
    end
    ovf = (t < -half) || (t >= half);
  endfunction

  task automatic chk(input string name, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a16"}, longint'(a16), 0);
    chk({tag, "_b16"}, longint'(b16), 0);
    chk({tag, "_sum16"}, longint'(sum16), 0);
    chk({tag, "_flags16"}, longint'({co16, ovf16, busy16, done16}), 0);
    chk({tag, "_a32"}, longint'(a32), 0);
    chk({tag, "_b32"}, longint'(b32), 0);
    chk({tag, "_sum32"}, longint'(sum32), 0);
    chk({tag, "_flags32"}, longint'({co32, ovf32, busy32, done32}), 0);
  endtask

  task automatic clear_model();
    q16.delete(); q32.delete();
    ma16 = 0; mb16 = 0; ms16 = 0;
    ma32 = 0; mb32 = 0; ms32 = 0;
  endtask

  // Monitor: every Done pops one expectation and checks value and arrival cycle.
  always @(negedge clk) begin
    if (reset_n && done16) begin
      total++;
      if (q16.size() == 0) begin
        bad++;
        $display("FAIL done16_unexpected cyc=%0d sum=%h", cyc, sum16);
      end else begin
        e16 = q16.pop_front();
        if (sum16 != 16'(e16.sum) || co16 != e16.co || ovf16 != e16.ovf || cyc != e16.cyc) begin
          bad++;
          $display("FAIL result16 got sum=%h co=%b ovf=%b cyc=%0d want sum=%h co=%b ovf=%b cyc=%0d",
                   sum16, co16, ovf16, cyc, 16'(e16.sum), e16.co, e16.ovf, e16.cyc);
        end else
          $display("op16 sum=%h co=%b ovf=%b cyc=%0d ok", sum16, co16, ovf16, cyc);
      end
    end
    if (reset_n && done32) begin
      total++;
      if (q32.size() == 0) begin
        bad++;
        $display("FAIL done32_unexpected cyc=%0d sum=%h", cyc, sum32);
      end else begin
        e32 = q32.pop_front();
        if (sum32 != 32'(e32.sum) || co32 != e32.co || ovf32 != e32.ovf || cyc != e32.cyc) begin
          bad++;
          $display("FAIL result32 got sum=%h co=%b ovf=%b cyc=%0d want sum=%h co=%b ovf=%b cyc=%0d",
                   sum32, co32, ovf32, cyc, 32'(e32.sum), e32.co, e32.ovf, e32.cyc);
        end else
          $display("op32 sum=%h co=%b ovf=%b cyc=%0d ok", sum32, co32, ovf32, cyc);
      end
    end
  end

  // sel[0] loads A, sel[1] loads B.
  task automatic load(input logic [1:0] sel, input logic [15:0] v16, input logic [31:0] v32);
    @(negedge clk);
    sw16 = v16; sw32 = v32;
    if (sel[0]) la = 1'b0;
    if (sel[1]) lb = 1'b0;
    @(negedge clk);
    la = 1'b1; lb = 1'b1;
    repeat (4) @(negedge clk);
    if (sel[0]) begin ma16 = longint'(v16); ma32 = longint'(v32); end
    if (sel[1]) begin mb16 = longint'(v16); mb32 = longint'(v32); end
    chk("a16", longint'(a16), ma16);
    chk("b16", longint'(b16), mb16);
    chk("a32", longint'(a32), ma32);
    chk("b32", longint'(b32), mb32);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk_zero("rst");
    clear_model();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  // opt[0]: second Run pulse sampled at E0+2; opt[1]: LoadB while busy.
  // rst_at >= 0: assert reset at E0+rst_at with Run held low through release.
  task automatic do_run(input logic [1:0] m, input logic [1:0] opt,
                        input logic [15:0] ld16, input logic [31:0] ld32, input int rst_at);
    longint r;
    bit     co, ov;
    int     n;
    exp_t   e;
    @(negedge clk);
    mode = m;
    n = cyc;
    ref_op(16, m, ma16, mb16, ms16, r, co, ov);
    e = '{r, co, ov, n + 3 + 4};
    q16.push_back(e);
    ms16 = r;
    ref_op(32, m, ma32, mb32, ms32, r, co, ov);
    e = '{r, co, ov, n + 3 + 8};
    q32.push_back(e);
    ms32 = r;
    run = 1'b0;
    for (int d = 1; d <= 12; d++) begin
      @(negedge clk);
      if (d == 1 && opt[0]) run = 1'b1;
      if (d == 2 && opt[0]) run = 1'b0;
      if (d == 4) run = 1'b1;
      if (d == 3 && opt[1]) begin sw16 = ld16; sw32 = ld32; lb = 1'b0; end
      if (d == 5 && opt[1]) begin lb = 1'b1; mb16 = longint'(ld16); mb32 = longint'(ld32); end
      if (rst_at >= 0 && d == 3 + rst_at) begin
        reset_n = 1'b0;
        run = 1'b0;
        #1;
        chk_zero("midrst");
        clear_model();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        run = 1'b1;
        for (int j = 0; j < 14; j++) begin
          @(negedge clk);
          chk("busy_after_rst", longint'({busy16, busy32}), 0);
        end
        return;
      end
      chk("busy16", longint'(busy16), longint'(d >= 3 && d < 3 + 4));
      chk("busy32", longint'(busy32), longint'(d >= 3 && d < 3 + 8));
    end
    chk("pending16", longint'(q16.size()), 0);
    chk("pending32", longint'(q32.size()), 0);
    q16.delete(); q32.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("init");
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    do_run(2'b00, 2'b00, 16'h0, 32'h0, -1);

    load(2'b01, 16'h1234, 32'h1234_5678);
    load(2'b10, 16'h4321, 32'h8765_4321);
    do_run(2'b00, 2'b00, 16'h0, 32'h0, -1);

    load(2'b11, 16'hFFFF, 32'hFFFF_FFFF);
    load(2'b10, 16'h0001, 32'h0000_0001);
    do_run(2'b00, 2'b00, 16'h0, 32'h0, -1);
    load(2'b01, 16'h7FFF, 32'h7FFF_FFFF);
    do_run(2'b00, 2'b00, 16'h0, 32'h0, -1);

    load(2'b01, 16'h8000, 32'h8000_0000);
    do_run(2'b01, 2'b00, 16'h0, 32'h0, -1);
    load(2'b01, 16'h0000, 32'h0000_0000);
    do_run(2'b01, 2'b00, 16'h0, 32'h0, -1);

    do_reset();
    load(2'b10, 16'h0003, 32'h0000_0003);
    do_run(2'b10, 2'b00, 16'h0, 32'h0, -1);
    do_run(2'b10, 2'b01, 16'h0, 32'h0, -1);
    do_run(2'b10, 2'b10, 16'h0005, 32'h0000_0005, -1);
    chk("sum16_acc", longint'(sum16), 16'h0009);
    chk("b16_loaded_busy", longint'(b16), 16'h0005);

    load(2'b01, 16'h1234, 32'h1234_5678);
    do_run(2'b00, 2'b00, 16'h0, 32'h0, 2);

    for (int i = 0; i < 20; i++) begin
      logic [1:0] sel;
      sel = 2'($urandom_range(0, 3));
      if (sel != 2'b00) load(sel, 16'($urandom), $urandom);
      do_run(2'($urandom_range(0, 3)), 2'b00, 16'h0, 32'h0, -1);
    end

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
